// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Parametrised single-clock synchronous FIFO with registered
//               read data, occupancy counter and registered status flags.
//               Depth need not be a power of two; pointers wrap at DEPTH-1.
//               Optional build macro FIFO_ERR_STICKY_EN makes overflow and
//               underflow sticky until reset (default: one-cycle pulses).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 80,
    parameter int ADDR_WIDTH = 7,
    parameter int AF_LEVEL   = 72,
    parameter int AE_LEVEL   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0]   c_depth     = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_af_level  = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   c_ae_level  = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH-1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almost_full;
    logic                  r_almost_empty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;
    logic                  w_overflow_evt;
    logic                  w_underflow_evt;
    logic                  w_overflow_nxt;
    logic                  w_underflow_nxt;

    // A write into a full FIFO is still accepted when a read frees a slot
    // in the same cycle; a read from an empty FIFO is never accepted, so
    // there is no write-through path to dout.
    assign w_wr_ok         = wr_en && (!r_full || rd_en);
    assign w_rd_ok         = rd_en && !r_empty;
    assign w_overflow_evt  = wr_en && !w_wr_ok;
    assign w_underflow_evt = rd_en && !w_rd_ok;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    assign w_wr_ptr_nxt = (r_wr_ptr == c_last_addr) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == c_last_addr) ? '0 : r_rd_ptr + 1'b1;

`ifdef FIFO_ERR_STICKY_EN
    assign w_overflow_nxt  = r_overflow  | w_overflow_evt;
    assign w_underflow_nxt = r_underflow | w_underflow_evt;
`else
    assign w_overflow_nxt  = w_overflow_evt;
    assign w_underflow_nxt = w_underflow_evt;
`endif

    // Next occupancy: simultaneous read and write cancel out.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_ok && !w_rd_ok) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_rd_ok && !w_wr_ok) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Storage array: not reset, and writes are suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, occupancy, read data and flags; flags are derived from the
    // next occupancy so they always agree with count after the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_dout         <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= w_rd_ptr_nxt;
                r_dout   <= r_mem[r_rd_ptr];
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == c_depth);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= c_af_level);
            r_almost_empty <= (w_count_nxt <= c_ae_level);
            r_overflow     <= w_overflow_nxt;
            r_underflow    <= w_underflow_nxt;
        end
    end

    assign dout         = r_dout;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Self-checking bench for sync_fifo_param. Instance A uses the
//               default 80x8 configuration with directed vectors; instance B
//               uses DEPTH=5, ADDR_WIDTH=3, DATA_WIDTH=16 with random traffic
//               against a reference queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    logic clk;
    int   n_vec = 0;
    int   n_err = 0;

    // Instance A signals
    logic        rst_a, wr_en_a, rd_en_a;
    logic [7:0]  din_a, dout_a;
    logic        full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
    logic [7:0]  count_a;

    // Instance B signals
    logic        rst_b, wr_en_b, rd_en_b;
    logic [15:0] din_b, dout_b;
    logic        full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
    logic [3:0]  count_b;

    // Reference model state
    logic [7:0]  qa [$];
    logic [7:0]  ea_dout;
    logic        ea_ovf, ea_udf;
    logic [15:0] qb [$];
    logic [15:0] eb_dout;
    logic        eb_ovf, eb_udf;

    sync_fifo_param u_dut_a (
        .clk          (clk),
        .rst          (rst_a),
        .wr_en        (wr_en_a),
        .din          (din_a),
        .rd_en        (rd_en_a),
        .dout         (dout_a),
        .full         (full_a),
        .empty        (empty_a),
        .almost_full  (af_a),
        .almost_empty (ae_a),
        .count        (count_a),
        .overflow     (ovf_a),
        .underflow    (udf_a)
    );

    sync_fifo_param #(
        .DATA_WIDTH (16),
        .DEPTH      (5),
        .ADDR_WIDTH (3),
        .AF_LEVEL   (4),
        .AE_LEVEL   (1)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst_b),
        .wr_en        (wr_en_b),
        .din          (din_b),
        .rd_en        (rd_en_b),
        .dout         (dout_b),
        .full         (full_b),
        .empty        (empty_b),
        .almost_full  (af_b),
        .almost_empty (ae_b),
        .count        (count_b),
        .overflow     (ovf_b),
        .underflow    (udf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic compare_a();
        check_val("a_count", 32'(count_a), 32'(qa.size()));
        check_val("a_empty", 32'(empty_a), 32'(qa.size() == 0));
        check_val("a_full",  32'(full_a),  32'(qa.size() == 80));
        check_val("a_afull", 32'(af_a),    32'(qa.size() >= 72));
        check_val("a_aempt", 32'(ae_a),    32'(qa.size() <= 8));
        check_val("a_ovf",   32'(ovf_a),   32'(ea_ovf));
        check_val("a_udf",   32'(udf_a),   32'(ea_udf));
        check_val("a_dout",  32'(dout_a),  32'(ea_dout));
    endtask

    task automatic compare_b();
        check_val("b_count", 32'(count_b), 32'(qb.size()));
        check_val("b_cmax",  32'(count_b <= 4'd5), 32'd1);
        check_val("b_empty", 32'(empty_b), 32'(qb.size() == 0));
        check_val("b_full",  32'(full_b),  32'(qb.size() == 5));
        check_val("b_afull", 32'(af_b),    32'(qb.size() >= 4));
        check_val("b_aempt", 32'(ae_b),    32'(qb.size() <= 1));
        check_val("b_ovf",   32'(ovf_b),   32'(eb_ovf));
        check_val("b_udf",   32'(udf_b),   32'(eb_udf));
        check_val("b_dout",  32'(dout_b),  32'(eb_dout));
    endtask

    // One clock of instance A with model update and full output comparison.
    task automatic step_a(input logic we, input logic [7:0] d, input logic re, input logic rs);
        logic wok, rok;
        wr_en_a = we; din_a = d; rd_en_a = re; rst_a = rs;
        @(posedge clk);
        #1;
        if (rs) begin
            qa.delete();
            ea_dout = '0; ea_ovf = 1'b0; ea_udf = 1'b0;
        end else begin
            rok = re && (qa.size() != 0);
            wok = we && ((qa.size() < 80) || re);
            if (rok) ea_dout = qa.pop_front();
            if (wok) qa.push_back(d);
`ifdef FIFO_ERR_STICKY_EN
            ea_ovf = ea_ovf | (we && !wok);
            ea_udf = ea_udf | (re && !rok);
`else
            ea_ovf = we && !wok;
            ea_udf = re && !rok;
`endif
        end
        compare_a();
    endtask

    task automatic step_b(input logic we, input logic [15:0] d, input logic re, input logic rs);
        logic wok, rok;
        wr_en_b = we; din_b = d; rd_en_b = re; rst_b = rs;
        @(posedge clk);
        #1;
        if (rs) begin
            qb.delete();
            eb_dout = '0; eb_ovf = 1'b0; eb_udf = 1'b0;
        end else begin
            rok = re && (qb.size() != 0);
            wok = we && ((qb.size() < 5) || re);
            if (rok) eb_dout = qb.pop_front();
            if (wok) qb.push_back(d);
`ifdef FIFO_ERR_STICKY_EN
            eb_ovf = eb_ovf | (we && !wok);
            eb_udf = eb_udf | (re && !rok);
`else
            eb_ovf = we && !wok;
            eb_udf = re && !rok;
`endif
        end
        compare_b();
    endtask

    initial begin
        rst_a = 1'b1; wr_en_a = 1'b0; rd_en_a = 1'b0; din_a = '0;
        rst_b = 1'b1; wr_en_b = 1'b0; rd_en_b = 1'b0; din_b = '0;
        ea_dout = '0; ea_ovf = 1'b0; ea_udf = 1'b0;
        eb_dout = '0; eb_ovf = 1'b0; eb_udf = 1'b0;

        // Reset state
        step_a(1'b0, 8'h00, 1'b0, 1'b1);
        step_a(1'b0, 8'h00, 1'b0, 1'b1);
        check_val("rst_count", 32'(count_a), 32'd0);
        check_val("rst_empty", 32'(empty_a), 32'd1);
        check_val("rst_aempt", 32'(ae_a),    32'd1);
        check_val("rst_full",  32'(full_a),  32'd0);
        check_val("rst_dout",  32'(dout_a),  32'd0);

        // Fill with 0x01..0x50, watching threshold crossings
        for (int i = 1; i <= 80; i++) begin
            step_a(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 8)  check_val("ae_at8",  32'(ae_a), 32'd1);
            if (i == 9)  check_val("ae_at9",  32'(ae_a), 32'd0);
            if (i == 71) check_val("af_at71", 32'(af_a), 32'd0);
            if (i == 72) check_val("af_at72", 32'(af_a), 32'd1);
        end
        check_val("fill_full",  32'(full_a),  32'd1);
        check_val("fill_count", 32'(count_a), 32'd80);

        // Write into full FIFO is rejected
        step_a(1'b1, 8'hAA, 1'b0, 1'b0);
        check_val("ovf_set",   32'(ovf_a),   32'd1);
        check_val("ovf_count", 32'(count_a), 32'd80);
        step_a(1'b0, 8'h00, 1'b0, 1'b0);

        // Drain in order, 0xAA must never appear
        for (int i = 1; i <= 80; i++) begin
            step_a(1'b0, 8'h00, 1'b1, 1'b0);
            check_val("rd_order", 32'(dout_a), 32'(i));
        end
        check_val("drain_empty", 32'(empty_a), 32'd1);

        // Read from empty is rejected, dout holds
        step_a(1'b0, 8'h00, 1'b1, 1'b0);
        check_val("udf_set",  32'(udf_a),   32'd1);
        check_val("udf_dout", 32'(dout_a),  32'h50);
        check_val("udf_cnt",  32'(count_a), 32'd0);

        // Simultaneous read/write on empty: write only, no write-through
        step_a(1'b1, 8'h5C, 1'b1, 1'b0);
        check_val("ew_count", 32'(count_a), 32'd1);
        check_val("ew_udf",   32'(udf_a),   32'd1);
        check_val("ew_empty", 32'(empty_a), 32'd0);
        check_val("ew_dout",  32'(dout_a),  32'h50);

        // Refill to full, then sustained read+write through pointer wraps
        for (int i = 0; i < 79; i++) step_a(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        check_val("refill_full", 32'(full_a), 32'd1);
        step_a(1'b1, 8'h00, 1'b1, 1'b0);
        check_val("fw_first", 32'(dout_a), 32'h5C);
        for (int i = 1; i < 200; i++) begin
            step_a(1'b1, 8'(i), 1'b1, 1'b0);
            check_val("fw_cnt80", 32'(count_a), 32'd80);
        end

        // Drain to 40 and reset mid-stream with a write pending
        for (int i = 0; i < 40; i++) step_a(1'b0, 8'h00, 1'b1, 1'b0);
        check_val("mid_count", 32'(count_a), 32'd40);
        step_a(1'b1, 8'h77, 1'b0, 1'b1);
        check_val("mrst_count", 32'(count_a), 32'd0);
        check_val("mrst_empty", 32'(empty_a), 32'd1);
        check_val("mrst_dout",  32'(dout_a),  32'd0);
        check_val("mrst_afull", 32'(af_a),    32'd0);
        step_a(1'b1, 8'h11, 1'b0, 1'b0);
        step_a(1'b0, 8'h00, 1'b1, 1'b0);
        check_val("post_rst_rd", 32'(dout_a), 32'h11);

        // DEPTH=5 instance with random traffic against the reference queue
        step_b(1'b0, 16'h0000, 1'b0, 1'b1);
        step_b(1'b0, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            step_b(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
